// File: rtl/op_enc_pkg.sv
// Shared encoding between the issue buffer and the control-unit decoder:
// ALU-op codes, 4-bit opcodes and the encode function mapping one to the other.
package op_enc_pkg;

  localparam int OPC_W   = 4;
  localparam int ALUOP_W = 2;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 2'b01;
  localparam logic [ALUOP_W-1:0] ALU_AND = 2'b10;
  localparam logic [ALUOP_W-1:0] ALU_NOP = 2'b11;

  localparam logic [OPC_W-1:0] OPC_ADD = 4'b0001;
  localparam logic [OPC_W-1:0] OPC_SUB = 4'b0011;
  localparam logic [OPC_W-1:0] OPC_AND = 4'b0100;
  // Falls into the decoder's default arm: no register write, no memory access.
  localparam logic [OPC_W-1:0] OPC_NOP = 4'b0000;

  function automatic logic [OPC_W-1:0] encode_op(input logic [ALUOP_W-1:0] alu_op);
    logic [OPC_W-1:0] opc;
    opc = OPC_NOP;
    unique case (alu_op)
      ALU_ADD: opc = OPC_ADD;
      ALU_SUB: opc = OPC_SUB;
      ALU_AND: opc = OPC_AND;
      default: opc = OPC_NOP;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/op_encode_issue_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; flush clears
// the pointers and count, and storage is reset so the head reads zero when empty.
module op_sync_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Full never accepts a push, even alongside a pop; flush overrides both.
  assign w_push = i_push && !w_full  && !i_flush;
  assign w_pop  = i_pop  && !w_empty && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/op_encode_issue.sv
// Encodes ALU-op requests into control-unit opcodes and buffers them for issue.
// Define OP_ENC_DROP_NOP_EN to accept NOP requests without enqueuing them.
module op_encode_issue
  import op_enc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RA_W  = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ALUOP_W-1:0]         req_op,
  input  logic [RA_W-1:0]            req_rd,
  input  logic [RA_W-1:0]            req_rs1,
  input  logic [RA_W-1:0]            req_rs2,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [OPC_W-1:0]           iss_opcode,
  output logic [RA_W-1:0]            iss_rd,
  output logic [RA_W-1:0]            iss_rs1,
  output logic [RA_W-1:0]            iss_rs2,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int WORD_W = OPC_W + 3 * RA_W;
  localparam int CW     = $clog2(DEPTH + 1);

  logic [OPC_W-1:0]  w_opcode;
  logic [WORD_W-1:0] w_wdata;
  logic [WORD_W-1:0] w_rdata;
  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_store;
  logic              w_push;
  logic              w_pop;

  // Opcode is fixed at push time; storage never sees the raw ALU op.
  assign w_opcode = encode_op(req_op);
  assign w_wdata  = {w_opcode, req_rd, req_rs1, req_rs2};

`ifdef OP_ENC_DROP_NOP_EN
  assign w_store = (req_op != ALU_NOP);
`else
  assign w_store = 1'b1;
`endif

  assign req_ready = !w_full;
  assign iss_valid = !w_empty;
  assign w_push    = req_valid && req_ready && w_store;
  assign w_pop     = iss_valid && iss_ready;

  op_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {iss_opcode, iss_rd, iss_rs1, iss_rs2} = w_rdata;
  assign count = w_count;

endmodule

// File: tb/tb_op_encode_issue.sv
// Randomised scoreboard bench for op_encode_issue against a queue-based reference model.
module tb_op_encode_issue;

  localparam int DEPTH = 4;
  localparam int RA_W  = 3;
  localparam int CW    = $clog2(DEPTH + 1);

`ifdef OP_ENC_DROP_NOP_EN
  localparam bit DROP_NOP = 1'b1;
`else
  localparam bit DROP_NOP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [RA_W-1:0] req_rd, req_rs1, req_rs2;
  logic            iss_valid;
  logic            iss_ready;
  logic [3:0]      iss_opcode;
  logic [RA_W-1:0] iss_rd, iss_rs1, iss_rs2;
  logic [CW-1:0]   count;

  typedef struct packed {
    logic [3:0]      opc;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
  } word_t;

  word_t exp_q[$];
  int    mcount;
  bit    p_store, p_pop, p_flush;
  bit    mon_en;
  int    checks = 0;
  int    errors = 0;

  op_encode_issue #(.DEPTH(DEPTH), .RA_W(RA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .iss_opcode (iss_opcode),
    .iss_rd     (iss_rd),
    .iss_rs1    (iss_rs1),
    .iss_rs2    (iss_rs2),
    .count      (count)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_opc(input logic [1:0] op);
    case (op)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      2'd2:    return 4'b0100;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: checks occupancy/handshake each cycle, compares the head against the
  // scoreboard while valid, and retires the expected word on every issue.
  always @(negedge clk) begin
    if (mon_en) begin
      check("count", int'(count), mcount);
      check("req_ready", int'(req_ready), int'(mcount != DEPTH));
      check("iss_valid", int'(iss_valid), int'(mcount != 0));
      if (iss_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL head_present actual=valid required=empty t=%0t", $time);
        end else begin
          check("opcode", int'(iss_opcode), int'(exp_q[0].opc));
          check("rd", int'(iss_rd), int'(exp_q[0].rd));
          check("rs1", int'(iss_rs1), int'(exp_q[0].rs1));
          check("rs2", int'(iss_rs2), int'(exp_q[0].rs2));
          if (iss_ready && !flush && rst_n) begin
            $display("issue opc=%b rd=%0d rs1=%0d rs2=%0d", iss_opcode, iss_rd, iss_rs1, iss_rs2);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic apply_pending();
    if (p_flush) begin
      mcount = 0;
      exp_q.delete();
    end else begin
      mcount = mcount + int'(p_store) - int'(p_pop);
    end
    p_store = 1'b0;
    p_pop   = 1'b0;
    p_flush = 1'b0;
  endtask

  task automatic step(input bit v, input logic [1:0] op, input bit fl, input bit ir);
    bit acc;
    @(posedge clk);
    #1;
    apply_pending();
    req_valid = v;
    req_op    = op;
    req_rd    = RA_W'($urandom);
    req_rs1   = RA_W'($urandom);
    req_rs2   = RA_W'($urandom);
    flush     = fl;
    iss_ready = ir;
    acc     = v && (mcount != DEPTH) && !fl;
    p_store = acc && !(DROP_NOP && op == 2'b11);
    p_pop   = ir && (mcount != 0) && !fl;
    p_flush = fl;
    if (p_store) exp_q.push_back('{ref_opc(op), req_rd, req_rs1, req_rs2});
    if (acc) $display("push op=%0d rd=%0d rs1=%0d rs2=%0d stored=%0d", op, req_rd, req_rs1, req_rs2, p_store);
    if (fl) $display("flush with valid=%0d", v);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = 2'd0;
    req_rd = '0; req_rs1 = '0; req_rs2 = '0; iss_ready = 1'b0;
    mcount = 0; p_store = 0; p_pop = 0; p_flush = 0; mon_en = 0;
    #12 rst_n = 1'b1;
    check("rst_count", int'(count), 0);
    check("rst_iss_valid", int'(iss_valid), 0);
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_opcode", int'(iss_opcode), 0);
    check("rst_fields", int'({iss_rd, iss_rs1, iss_rs2}), 0);
    mon_en = 1'b1;

    // Encoding: ADD, SUB, AND held, then drained in order
    step(1, 2'd0, 0, 0); step(1, 2'd1, 0, 0); step(1, 2'd2, 0, 0);
    step(0, 2'd0, 0, 0);
    drain(4);

    // Full and backpressure: five pushes into a depth-4 buffer
    for (int i = 0; i < 5; i++) step(1, 2'($urandom_range(0, 2)), 0, 0);
    step(0, 2'd0, 0, 0);
    drain(5);

    // Streaming with alternating ops
    for (int i = 0; i < 20; i++) step(1, 2'(i % 3), 0, 1);
    drain(2);

    // Flush with a simultaneous push at count 3
    for (int i = 0; i < 3; i++) step(1, 2'd1, 0, 0);
    step(1, 2'd0, 1, 0);
    step(0, 2'd0, 0, 0);
    step(0, 2'd0, 0, 1);

    // Asynchronous reset between edges at count 2
    step(1, 2'd0, 0, 0); step(1, 2'd2, 0, 0);
    @(posedge clk);
    #1;
    apply_pending();
    req_valid = 1'b0; iss_ready = 1'b0;
    #2 rst_n = 1'b0;
    mcount = 0;
    exp_q.delete();
    #1;
    check("midrst_iss_valid", int'(iss_valid), 0);
    check("midrst_req_ready", int'(req_ready), 1);
    check("midrst_count", int'(count), 0);
    check("midrst_opcode", int'(iss_opcode), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(0, 2'd0, 0, 1);

    // NOP then ADD
    step(1, 2'd3, 0, 0); step(1, 2'd0, 0, 0);
    step(0, 2'd0, 0, 0);
    drain(3);

    // Randomised traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 2'($urandom), ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
    drain(DEPTH + 2);
    @(posedge clk);
    #1;
    apply_pending();
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("final_scoreboard_empty", exp_q.size(), 0);
    check("final_count", int'(count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
